// File: rtl/ysyx_22040750_ifu.sv
// ysyx_22040750_ifu: single-outstanding instruction fetch unit (optional misaligned-dnpc trap via YSYX_22040750_IFU_MISALIGN_TRAP_EN)
module ysyx_22040750_ifu #(
   parameter logic [31:0] RST_PC = 32'h8000_0000
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_pc_valid,
   input  logic [31:0] I_dnpc,
   output logic        O_pc_ready,
   output logic        O_imem_req_valid,
   output logic [31:0] O_imem_addr,
   input  logic        I_imem_req_ready,
   input  logic        I_imem_rsp_valid,
   input  logic [31:0] I_imem_rsp_data,
   output logic        O_imem_rsp_ready,
   output logic        O_IF_ID_valid,
   output logic [31:0] O_IF_ID_pc,
   output logic [31:0] O_IF_ID_inst,
   output logic        O_IF_ID_misalign,
   input  logic        I_IF_ID_ready
);
   typedef enum logic [1:0] {REQ, WAIT, HOLD, NEXT} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, inst_q, inst_d;
   logic        mis_q, mis_d, dnpc_mis;
`ifdef YSYX_22040750_IFU_MISALIGN_TRAP_EN
   assign dnpc_mis = |I_dnpc[1:0];
`else
   assign dnpc_mis = 1'b0;
`endif
   // each handshake signal lives only in its own state and is silenced during reset
   assign O_imem_req_valid = ~I_rst & (state_q == REQ);
   assign O_imem_rsp_ready = ~I_rst & (state_q == WAIT);
   assign O_IF_ID_valid    = ~I_rst & (state_q == HOLD);
   assign O_pc_ready       = ~I_rst & (state_q == NEXT);
   assign O_imem_addr      = pc_q;
   assign O_IF_ID_pc       = I_rst ? 32'h0 : pc_q;
   assign O_IF_ID_inst     = inst_q;
   assign O_IF_ID_misalign = O_IF_ID_valid & mis_q;
   // next-state: request, wait for data, present to decode, take the next dnpc
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      mis_d   = mis_q;
      case (state_q)
         REQ:  state_d = I_imem_req_ready ? WAIT : REQ;
         WAIT: if (I_imem_rsp_valid) begin
            inst_d  = I_imem_rsp_data;
            mis_d   = 1'b0;
            state_d = HOLD;
         end
         HOLD: state_d = I_IF_ID_ready ? NEXT : HOLD;
         NEXT: if (I_pc_valid) begin
            pc_d    = I_dnpc;
            inst_d  = dnpc_mis ? 32'h0000_0013 : inst_q;
            mis_d   = dnpc_mis;
            state_d = dnpc_mis ? HOLD : REQ;
         end
      endcase
   end
   // state and datapath registers with synchronous reset
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q <= REQ;
         pc_q    <= RST_PC;
         inst_q  <= 32'h0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         mis_q   <= mis_d;
      end
   end
endmodule
